req_resp_delay: RTL and testbench
=================================

REQ_RESP_DELAY -- requirements
Module: req_resp_delay

Interface
REQ-001 Parameter DEPTH, default 4: maximum outstanding requests.
REQ-002 Parameter CNT_W, default 8: width of the delay value and timestamp counter.
REQ-003 Parameter DELAY_RST, default 4: delay loaded at reset.
REQ-004 Port clk, input, 1: single clock; all logic updates on posedge clk.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port en_i, input, 1: request acceptance enable.
REQ-007 Port req_i, input, 1: request strobe, sampled each posedge.
REQ-008 Port delay_i, input, CNT_W: requested req-to-ack latency in cycles.
REQ-009 Port flush_i, input, 1: discard all pending requests.
REQ-010 Port clr_ovf_i, input, 1: clear sticky overflow.
REQ-011 Port ack_o, output, 1: single-cycle response strobe, registered.
REQ-012 Port busy_o, output, 1: at least one request pending.
REQ-013 Port outstanding_o, output, $clog2(DEPTH+1): pending request count.
REQ-014 Port overflow_o, output, 1: sticky flag, a request was dropped.
REQ-015 Port delay_o, output, CNT_W: currently active delay D.

Function
REQ-016 Request sampled high at posedge T and accepted -> ack_o sampled high at posedge T+D only, i.e. req |-> ##D ack, one cycle wide per request.
REQ-017 D = delay_i, or 1 if delay_i == 0; loaded only on a posedge where outstanding is 0 and no request is accepted on that same edge; ignored while busy.
REQ-018 Accept = req_i & en_i & (outstanding < DEPTH, or an ack retires on the same edge).
REQ-019 Accepted request pushes deadline = ts + D into an in-order deadline buffer; ts is a free-running CNT_W+1-bit counter that wraps modulo 2^(CNT_W+1).
REQ-020 Head entry retires when ts == head deadline, driving ack_o high for the next cycle; comparison is modulo wrap, so wrap-around gives no spurious or missed acks.
REQ-021 Back-to-back requests on consecutive edges each produce their own ack D cycles later; ack_o is high on consecutive cycles accordingly.
REQ-022 Request with buffer full and no same-edge retire is dropped and sets overflow_o; overflow_o stays 1 until clr_ovf_i; a set on the same edge wins over clear.
REQ-023 en_i low blocks new acceptance only; pending requests still complete.
REQ-024 flush_i empties the buffer on that edge, suppresses any ack due on that edge, and ignores req_i on that edge.
REQ-025 FSM: IDLE (outstanding 0) -> ACTIVE on accept; ACTIVE -> IDLE when the last entry retires with no same-edge accept, or on flush. busy_o = (state == ACTIVE).
REQ-026 outstanding_o = pushes minus retires, updated each edge; simultaneous push and retire leaves it unchanged.

Reset
REQ-027 On a posedge with rst_n low: ack_o 0, busy_o 0, outstanding_o 0, overflow_o 0, delay_o DELAY_RST (0 maps to 1), ts 0, buffer empty, state IDLE.
REQ-028 Reset mid-operation discards pending requests; no ack is issued for them after rst_n returns high.

Structure
REQ-029 Package req_resp_pkg SHALL hold the FSM state enum (IDLE, ACTIVE) and the default DEPTH, CNT_W and DELAY_RST constants.
REQ-030 Deadline storage SHALL be one sub-module, req_resp_fifo: DEPTH x (CNT_W+1) synchronous FIFO with push, pop, flush, full, empty and count.

Verification
REQ-031 D=4, req pulses at cycles 1 and 10 -> ack high at cycles 5 and 14 only; checked with an assertion equivalent to req |-> ##4 ack.
REQ-032 D=4, req on cycles 3 and 4 -> ack on cycles 7 and 8; outstanding_o peaks at 2; busy_o falls after cycle 8.
REQ-033 DEPTH=4, D=8, req on cycles 1-5 -> 5th request dropped, overflow_o=1, exactly 4 acks (cycles 9-12); clr_ovf_i clears overflow_o.
REQ-034 delay_i changed 4->6 while busy -> pending acks keep D=4; first request after IDLE acks at +6; delay_i=0 -> ack at +1.
REQ-035 rst_n low at cycle 3 after req at cycle 1 (D=4) -> no ack at cycle 5, all outputs at reset values; flush_i gives the same no-ack result.
REQ-036 CNT_W=3, D=7, continuous single requests across many ts wraps -> every request gets exactly one ack D cycles later.

Source files
------------

// File: rtl/req_resp_pkg.sv
// Shared types and default sizing for the request/response delay block.
// Pure declarations: no latency and no flow control of its own.
package req_resp_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int DEPTH_DEF     = 4;
  localparam int CNT_W_DEF     = 8;
  localparam int DELAY_RST_DEF = 4;

endpackage

// File: rtl/req_resp_fifo.sv
// In-order deadline store: DEPTH x W synchronous FIFO, registered count, flush wins.
// Push on a full FIFO is taken only when a pop happens on the same edge.
module req_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/req_resp_delay.sv
// Acks each accepted request exactly D cycles later via timestamped in-order deadlines.
// No backpressure: requests beyond DEPTH outstanding are dropped and flagged in overflow_o.
module req_resp_delay
  import req_resp_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DELAY_RST = DELAY_RST_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       req_i,
  input  logic [CNT_W-1:0]           delay_i,
  input  logic                       flush_i,
  input  logic                       clr_ovf_i,
  output logic                       ack_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           delay_o
);

  localparam int TW = CNT_W + 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DELAY_RST_V =
    (DELAY_RST == 0) ? CNT_W'(1) : CNT_W'(DELAY_RST);

  state_e           state_q;
  logic [TW-1:0]    ts_q, ts_d;
  logic [CNT_W-1:0] delay_q, delay_d, delay_norm;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;

  logic [TW-1:0]    head, deadline;
  logic             fifo_full, fifo_empty;
  logic [OW-1:0]    fifo_cnt;
  logic             req_v, retire, accept, bypass, push, pop;

  assign ts_d       = ts_q + TW'(1);
  assign delay_norm = (delay_i == '0) ? CNT_W'(1) : delay_i;
  assign deadline   = ts_q + {1'b0, delay_q};

  // Matching against the post-edge timestamp makes ack_o visible right at T+D.
  assign req_v  = req_i & en_i & ~flush_i;
  assign retire = ~fifo_empty & (head == ts_d);
  assign accept = req_v & (~fifo_full | retire);
  // D=1 acks on the accepting edge itself, so such requests never touch the FIFO.
  assign bypass = accept & (delay_q == CNT_W'(1));
  assign push   = accept & ~bypass;
  assign pop    = retire & ~flush_i;

  assign ack_d   = pop | bypass;
  assign ovf_d   = (req_v & ~accept) | (ovf_q & ~clr_ovf_i);
  assign delay_d = (fifo_empty & ~accept) ? delay_norm : delay_q;

  req_resp_fifo #(
    .DEPTH (DEPTH),
    .W     (TW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .din_i   (deadline),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q    <= '0;
      delay_q <= DELAY_RST_V;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      delay_q <= delay_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (flush_i || (pop && !push && fifo_cnt == OW'(1))) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o         = ack_q;
  assign busy_o        = (state_q == ACTIVE);
  assign outstanding_o = fifo_cnt;
  assign overflow_o    = ovf_q;
  assign delay_o       = delay_q;

endmodule

// File: tb/tb_req_resp_delay.sv
// Scoreboard bench for req_resp_delay: default instance plus a narrow-counter instance.
module tb_req_resp_delay;

  logic       clk;
  logic       rst_n, en_i, req_i, flush_i, clr_ovf_i;
  logic [7:0] delay_i;
  logic       ack_o, busy_o, overflow_o;
  logic [2:0] outstanding_o;
  logic [7:0] delay_o;

  logic       w_rst_n, w_req;
  logic [2:0] w_delay;
  logic       w_ack, w_busy, w_ovf;
  logic [2:0] w_out;
  logic [2:0] w_dly_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int a31_fail = 0;
  bit a31_on = 0;
  bit chk_on = 0;

  int mdl[$];
  int sb[$];
  int wq[$];
  int m_d = 4;
  bit m_ovf = 0;

  req_resp_delay u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .req_i(req_i), .delay_i(delay_i),
    .flush_i(flush_i), .clr_ovf_i(clr_ovf_i), .ack_o(ack_o), .busy_o(busy_o),
    .outstanding_o(outstanding_o), .overflow_o(overflow_o), .delay_o(delay_o)
  );

  req_resp_delay #(.DEPTH(4), .CNT_W(3), .DELAY_RST(7)) u_w (
    .clk(clk), .rst_n(w_rst_n), .en_i(1'b1), .req_i(w_req), .delay_i(w_delay),
    .flush_i(1'b0), .clr_ovf_i(1'b0), .ack_o(w_ack), .busy_o(w_busy),
    .outstanding_o(w_out), .overflow_o(w_ovf), .delay_o(w_dly_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  a31_prop: assert property (@(posedge clk) (a31_on && req_i) |-> ##4 ack_o)
    else a31_fail++;

  // Reference model: queue of ack cycles, evaluated on every edge.
  always @(posedge clk) begin
    int cnt;
    bit ret, acc;
    cyc++;
    if (!rst_n) begin
      mdl.delete();
      sb.delete();
      m_d = 4;
      m_ovf = 0;
    end else begin
      cnt = mdl.size();
      ret = !flush_i && cnt > 0 && mdl[0] == cyc;
      acc = req_i && en_i && !flush_i && (cnt < 4 || ret);
      if (flush_i) begin
        mdl.delete();
        sb.delete();
      end else begin
        if (ret) void'(mdl.pop_front());
        if (acc) begin
          if (m_d == 1) sb.push_back(cyc);
          else begin
            mdl.push_back(cyc + m_d - 1);
            sb.push_back(cyc + m_d - 1);
          end
        end
      end
      if (req_i && en_i && !flush_i && !acc) m_ovf = 1;
      else if (clr_ovf_i) m_ovf = 0;
      if (cnt == 0 && !acc) m_d = (delay_i == 0) ? 1 : int'(delay_i);
    end
  end

  always @(negedge clk) begin
    bit exp, wexp;
    if (chk_on) begin
      exp = sb.size() > 0 && sb[0] == cyc;
      if (exp || ack_o) chk("ack", ack_o, exp);
      if (exp) void'(sb.pop_front());
      chk("outstanding", outstanding_o, mdl.size());
      chk("busy", busy_o, mdl.size() != 0);
      chk("overflow", overflow_o, m_ovf);
      chk("delay", delay_o, m_d);
      wexp = wq.size() > 0 && wq[0] == cyc;
      if (wexp || w_ack) chk("w_ack", w_ack, wexp);
      if (wexp) void'(wq.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    repeat (n) begin
      @(negedge clk);
      if (ack_o) acks++;
    end
  endtask

  initial begin
    int acks;
    rst_n = 0; en_i = 1; req_i = 0; delay_i = 8'd4; flush_i = 0; clr_ovf_i = 0;
    w_rst_n = 0; w_req = 0; w_delay = 3'd7;
    idle(3);
    chk("rst_ack", ack_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_out", outstanding_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_delay", delay_o, 4);
    rst_n = 1; w_rst_n = 1; chk_on = 1;
    idle(2);

    // Isolated requests with D=4 under the concurrent check
    a31_on = 1;
    pulse(); idle(8);
    pulse(); idle(8);
    a31_on = 0;
    chk("a31_assert", a31_fail, 0);

    // Back-to-back pair
    req_i = 1; idle(2); req_i = 0;
    chk("peak_out", outstanding_o, 2);
    idle(8);
    chk("b2b_idle", busy_o, 0);

    // Overflow with D=8, five requests into DEPTH=4
    delay_i = 8'd8; idle(2);
    req_i = 1; idle(5); req_i = 0;
    chk("ovf_set", overflow_o, 1);
    count_acks(12, acks);
    chk("ovf_acks", acks, 4);
    clr_ovf_i = 1; idle(1); clr_ovf_i = 0;
    chk("ovf_clr", overflow_o, 0);

    // Delay change while busy, then reload once idle
    delay_i = 8'd4; idle(2);
    pulse(); delay_i = 8'd6; pulse();
    chk("d_hold", delay_o, 4);
    idle(8);
    chk("d_new", delay_o, 6);
    pulse(); idle(8);
    delay_i = 8'd0; idle(2);
    chk("d_zero", delay_o, 1);
    pulse(); pulse(); idle(3);

    // en_i low blocks new requests but pending ones finish
    delay_i = 8'd5; idle(2);
    pulse(); en_i = 0; pulse(); idle(6); en_i = 1;
    chk("en_no_ovf", overflow_o, 0);

    // Reset mid-flight discards the pending request
    delay_i = 8'd4; idle(2);
    pulse(); idle(1);
    rst_n = 0; idle(1); rst_n = 1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_out", outstanding_o, 0);
    chk("mid_rst_delay", delay_o, 4);
    count_acks(6, acks);
    chk("mid_rst_acks", acks, 0);

    // Flush behaves the same way
    pulse(); idle(1);
    flush_i = 1; idle(1); flush_i = 0;
    chk("flush_out", outstanding_o, 0);
    count_acks(6, acks);
    chk("flush_acks", acks, 0);

    // Random traffic against the model
    repeat (300) begin
      req_i     = ($urandom_range(0, 99) < 50);
      en_i      = ($urandom_range(0, 99) < 90);
      flush_i   = ($urandom_range(0, 99) < 3);
      clr_ovf_i = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 9) == 0) delay_i = 8'($urandom_range(0, 10));
      @(negedge clk);
    end
    req_i = 0; en_i = 1; flush_i = 0; clr_ovf_i = 0;
    idle(15);

    // Narrow counter: D=7 across many timestamp wraps
    for (int i = 0; i < 40; i++) begin
      w_req = 1;
      wq.push_back(cyc + 7);
      @(negedge clk);
      w_req = 0;
      idle($urandom_range(1, 2));
    end
    idle(10);
    chk("w_drain", wq.size(), 0);
    chk("w_no_ovf", w_ovf, 0);
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
